// File: rtl/ks_pkg.sv
// Shared types and defaults for the Kogge-Stone adder scheduler.
package ks_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LAT_DEF   = 3;
  localparam int NREQ_DEF  = 4;
  localparam int NREQ_MAX  = 8;

  // The id field is sized for the largest supported requester count.
  localparam int IDW = $clog2(NREQ_MAX);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the lowest valid requester at or after the
// pointer, wrapping, and advances the pointer past each granted requester.
module rr_arb
  import ks_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] req_hi;
  logic            any_hi, any_lo, grant_any;
  logic [IDW-1:0]  id_hi, id_lo, id_sel;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    req_hi     = '0;
    any_hi     = 1'b0;
    any_lo     = 1'b0;
    id_hi      = '0;
    id_lo      = '0;
    o_grant    = '0;
    o_grant_id = '0;
    ptr_d      = ptr_q;

    for (int k = 0; k < NREQ; k++) begin
      req_hi[k] = i_req[k] && (k >= int'(ptr_q));
    end

    // Walk downwards so the lowest index found is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_hi[k]) begin
        any_hi = 1'b1;
        id_hi  = IDW'(k);
      end
      if (i_req[k]) begin
        any_lo = 1'b1;
        id_lo  = IDW'(k);
      end
    end

    grant_any = i_en && any_lo;
    id_sel    = any_hi ? id_hi : id_lo;

    for (int k = 0; k < NREQ; k++) begin
      o_grant[k] = grant_any && (id_sel == IDW'(k));
    end

    if (grant_any) begin
      o_grant_id = id_sel;
      ptr_d      = (id_sel == IDW'(NREQ - 1)) ? '0 : id_sel + IDW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ks_add_sched.sv
// Shares one pipelined adder among NREQ requesters: round-robin issue,
// requester-id tag pipeline matching the adder latency, one-cycle response.
module ks_add_sched
  import ks_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  input  logic [NREQ-1:0]       i_req_cin,
  output logic                  o_add_valid,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  output logic                  o_add_c0,
  input  logic [WIDTH-1:0]      i_add_sum,
  input  logic                  i_add_cout,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout,
  output logic                  o_busy
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_req      (i_req_valid),
    .o_grant    (grant),
    .o_grant_id (grant_id)
  );

  assign o_req_ready = grant;
  assign o_add_valid = |grant;

  // Grant is one-hot or zero, so at most one requester drives the adder.
  always_comb begin
    o_add_a  = '0;
    o_add_b  = '0;
    o_add_c0 = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        o_add_a  = i_req_a[k*WIDTH +: WIDTH];
        o_add_b  = i_req_b[k*WIDTH +: WIDTH];
        o_add_c0 = i_req_cin[k];
      end
    end
  end

  tag_t [LAT-1:0]  tag_q, tag_d;
  tag_t            tag_last;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;

  always_comb begin
    tag_d[0] = '{vld: |grant, id: grant_id};
    for (int s = 1; s < LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // The adder result lines up with the last tag stage; sum/cout hold otherwise.
  always_comb begin
    tag_last    = tag_q[LAT-1];
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (tag_last.vld) begin
      rsp_sum_d  = i_add_sum;
      rsp_cout_d = i_add_cout;
      for (int k = 0; k < NREQ; k++) begin
        rsp_valid_d[k] = (tag_last.id == IDW'(k));
      end
    end
  end

  always_comb begin
    o_busy = |rsp_valid_q;
    for (int s = 0; s < LAT; s++) begin
      o_busy = o_busy | tag_q[s].vld;
    end
  end

  // NOTE: the tag pipeline is reset, not just its head, so ops in flight at
  // reset can never surface as a response afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_cout  = rsp_cout_q;

endmodule
